reg_bank_ctrl: RTL and testbench
================================

Name: reg_bank_ctrl

Overview:
Command sequencer that sits directly upstream of the 4x8 register-file top (the decoder, register bank and read mux) and drives its `wr`/`addr`/`d` inputs.
- Accepts single write, read and (optionally) clear commands over a valid/ready command channel.
- Performs the register-file access with correct timing.
- Returns exactly one response per command over a valid/ready response channel.

Parameters:
DW, 8, data width; must match register-file data width
AW, 2, address width; register count NREG = 2**AW

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  2  00 write, 01 read, 10 clear, 11 reserved
cmd_addr  input  AW  target register
cmd_data  input  DW  write data (ignored for read/clear)
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  DW  read data / echoed write data / 0
rsp_err  output  1  command rejected
rf_wr  output  1  register-file write strobe (to wr)
rf_addr  output  AW  register-file address (to addr)
rf_d  output  DW  register-file write data (to d)
rf_q  input  DW  register-file read data (from q, combinational on rf_addr)
busy  output  1  high in every state except IDLE

Behaviour:
- The interface has one clock; reset is synchronous and active-high. Ports are named `clk` and `rst`.
- All outputs are registered or decoded from the state register. There is no combinational path from cmd_* or rsp_ready to any output.
- Reset values: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, rf_wr=0, rf_addr=0, rf_d=0, busy=0.
- States: IDLE, WRITE, READ, CLEAR, RESP.
- IDLE:
  - cmd_ready=1.
  - A command is accepted on a cycle with cmd_valid&cmd_ready; cmd_op, cmd_addr and cmd_data are captured.
  - Next state: op 00 -> WRITE; 01 -> READ; 10 -> CLEAR (macro enabled) else RESP with error; 11 -> RESP with rsp_err=1 and rsp_data=0.
- WRITE (1 cycle):
  - rf_wr=1, rf_addr=captured addr, rf_d=captured data.
  - The register is updated at the end of this cycle.
  - rsp_data is loaded with the captured data; go to RESP.
- READ (1 cycle):
  - rf_wr=0, rf_addr=captured addr.
  - rf_q is sampled into rsp_data at the end of the cycle; go to RESP.
- RESP:
  - rsp_valid=1. rsp_data and rsp_err stay stable until rsp_ready=1.
  - On the handshake cycle: rsp_valid drops next cycle, return to IDLE.
  - rsp_data and rsp_err hold their last values afterwards.
- Latency from the accept edge (cycle N):
  - write: rf_wr high in N+1, rsp_valid from N+2.
  - read: rsp_valid from N+2.
  - reserved op: rsp_valid from N+1.
  - Minimum command-to-command spacing: 3 cycles for write/read with rsp_ready held high.
- cmd_ready=0 in every non-IDLE state; no command is accepted while busy.
- rf_addr and rf_d hold their last driven values outside WRITE, READ and CLEAR. rf_wr is high only in WRITE and CLEAR.
- Address wrap: a counter over NREG registers wraps naturally at 2**AW; no out-of-range address exists.
- Reset mid-operation: the next edge forces IDLE and rf_wr=0. A pending response is discarded and a CLEAR sequence is aborted; registers already cleared stay cleared.
- Simultaneous rsp handshake and new cmd_valid: the command is not accepted until the following cycle, when the controller is back in IDLE.

Optional Feature:
Macro REGCTRL_CLEAR_EN.
- Defined: op 10 enters CLEAR, which runs NREG cycles with rf_wr=1, rf_d=0 and rf_addr counting 0..NREG-1. The response follows with rsp_data=0, rsp_err=0.
- Latency for NREG=4: rf_wr high in N+1..N+4, rsp_valid from N+5.
- Undefined: the CLEAR state and counter are absent; op 10 is handled exactly like op 11 (rsp_err=1, rsp_data=0, no rf_wr).

Test Plan:
- After reset, write 0xA5 to addr 2 (rsp_ready=1): rf_wr pulses one cycle with rf_addr=2, rf_d=0xA5; rsp_valid=1, rsp_data=0xA5, rsp_err=0 two cycles after accept.
- Write 0x11/0x22/0x33/0x44 to addr 0..3, then read addr 3 then addr 0: rsp_data=0x44 then 0x11; rf_wr stays 0 during reads.
- Read addr 1 with rsp_ready=0 for 5 cycles: rsp_valid and rsp_data=0x22 held stable, cmd_ready=0, busy=1 throughout; after rsp_ready=1, IDLE next cycle.
- Op 11 with data 0xFF: rsp_valid one cycle after accept, rsp_err=1, rsp_data=0, register contents unchanged on subsequent reads.
- With REGCTRL_CLEAR_EN: op 10 -> 4 consecutive rf_wr pulses at addr 0,1,2,3 with d=0; all subsequent reads return 0x00. Without it: rsp_err=1, no rf_wr.
- Assert rst during the 2nd cycle of CLEAR: rf_wr=0 and state IDLE next cycle, no response; reads return addr0=addr1=0, addr2=0x33, addr3=0x44.

Source files
------------

// File: rtl/reg_bank_ctrl.sv
// Command sequencer in front of the 4x8 register file: accepts write/read/clear
// commands, drives wr/addr/d with correct timing and returns one response per command.
// Optional feature: define REGCTRL_CLEAR_EN to enable the multi-cycle CLEAR command (op 10).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid is never withdrawn and the payload never changes until that transfer occurs.
module reg_bank_ctrl #(
   parameter int DW = 8,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_data,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_err,
   output logic          rf_wr,
   output logic [AW-1:0] rf_addr,
   output logic [DW-1:0] rf_d,
   input  logic [DW-1:0] rf_q,
   output logic          busy,
   output logic [2:0]    state_dbg
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] WRITE = 3'd1;
   localparam logic [2:0] READ  = 3'd2;
   localparam logic [2:0] RESP  = 3'd4;
   localparam logic [1:0] OP_WR = 2'b00;
   localparam logic [1:0] OP_RD = 2'b01;
`ifdef REGCTRL_CLEAR_EN
   localparam logic [2:0]    CLEAR     = 3'd3;
   localparam logic [1:0]    OP_CLR    = 2'b10;
   localparam logic [AW-1:0] LAST_ADDR = '1;
`endif

   logic [2:0] state;

   // rf_addr/rf_d double as the captured command fields, so they only move on
   // accept (or while clearing) and otherwise hold their last driven value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
         rf_addr  <= '0;
         rf_d     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  case (cmd_op)
                     OP_WR: begin
                        state   <= WRITE;
                        rf_addr <= cmd_addr;
                        rf_d    <= cmd_data;
                     end
                     OP_RD: begin
                        state   <= READ;
                        rf_addr <= cmd_addr;
                     end
`ifdef REGCTRL_CLEAR_EN
                     OP_CLR: begin
                        state   <= CLEAR;
                        rf_addr <= '0;
                        rf_d    <= '0;
                     end
`endif
                     default: begin
                        state    <= RESP;
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                     end
                  endcase
               end
            end
            WRITE: begin
               state    <= RESP;
               rsp_data <= rf_d;
               rsp_err  <= 1'b0;
            end
            READ: begin
               state    <= RESP;
               rsp_data <= rf_q;
               rsp_err  <= 1'b0;
            end
`ifdef REGCTRL_CLEAR_EN
            CLEAR: begin
               // Stop at the last register without wrapping so rf_addr keeps its final value.
               if (rf_addr == LAST_ADDR) begin
                  state    <= RESP;
                  rsp_data <= '0;
                  rsp_err  <= 1'b0;
               end else begin
                  rf_addr <= rf_addr + AW'(1);
               end
            end
`endif
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign rsp_valid = (state == RESP);
   assign state_dbg = state;
`ifdef REGCTRL_CLEAR_EN
   assign rf_wr = (state == WRITE) || (state == CLEAR);
`else
   assign rf_wr = (state == WRITE);
`endif

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Directed bench for reg_bank_ctrl with a behavioural 4x8 register file attached;
// responses and register-file writes are checked against expected queues.
`timescale 1ns/1ps
module tb_reg_bank_ctrl;
   localparam int DW = 8;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b00;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_data = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic          rf_wr;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_d;
   logic [DW-1:0] rf_q;
   logic          busy;
   logic [2:0]    state_dbg;

   int total = 0;
   int bad   = 0;

   logic [DW:0]      exp_q[$];
   logic [AW+DW-1:0] wr_q[$];

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   reg_bank_ctrl #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_d(rf_d), .rf_q(rf_q),
      .busy(busy), .state_dbg(state_dbg)
   );

   // register file the controller drives
   logic [DW-1:0] rf_mem [4] = '{default: '0};
   always @(posedge clk) if (rf_wr) rf_mem[rf_addr] <= rf_d;
   assign rf_q = rf_mem[rf_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard monitors
   always begin
      logic [DW:0] e;
      @(negedge clk);
      #1;
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got data 0x%0h err %0b expected no response", rsp_data, rsp_err);
         end else begin
            e = exp_q.pop_front();
            check("rsp_data", rsp_data, e[DW-1:0]);
            check("rsp_err", rsp_err, e[DW]);
         end
      end
   end

   always begin
      logic [AW+DW-1:0] w;
      @(negedge clk);
      #1;
      if (rf_wr) begin
         if (wr_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rf_wr_unexpected: got write addr %0d d 0x%0h expected none", rf_addr, rf_d);
         end else begin
            w = wr_q.pop_front();
            check("rf_addr", rf_addr, w[AW+DW-1:DW]);
            check("rf_d", rf_d, w[DW-1:0]);
         end
      end
   end

   // driver tasks (called and returning on a falling edge)
   task automatic expect_rsp(input logic err, input logic [DW-1:0] d);
      exp_q.push_back({err, d});
   endtask

   task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_q.push_back({a, d});
   endtask

   task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check("cmd_ready_timeout", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_data  = d;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_data  = $urandom_range(0, 255);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!(cmd_ready && exp_q.size() == 0 && wr_q.size() == 0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("done_timeout", exp_q.size() + wr_q.size(), 0);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      expect_wr(a, d);
      expect_rsp(1'b0, d);
      send(2'b00, a, d);
      wait_done();
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
      expect_rsp(1'b0, d);
      send(2'b01, a, '0);
      wait_done();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_rf_wr", rf_wr, 0);
      check("rst_rf_addr", rf_addr, 0);
      check("rst_rf_d", rf_d, 0);
      check("rst_busy", busy, 0);
      check("rst_state", state_dbg, 3'd0);
      rst = 1'b0;
      @(negedge clk);

      // single write with latency checks
      expect_wr(2, 8'hA5);
      expect_rsp(1'b0, 8'hA5);
      send(2'b00, 2, 8'hA5);
      check("wr_n1_rf_wr", rf_wr, 1);
      check("wr_n1_rf_addr", rf_addr, 2);
      check("wr_n1_rf_d", rf_d, 8'hA5);
      check("wr_n1_rsp_valid", rsp_valid, 0);
      check("wr_n1_cmd_ready", cmd_ready, 0);
      check("wr_n1_busy", busy, 1);
      @(negedge clk);
      check("wr_n2_rsp_valid", rsp_valid, 1);
      check("wr_n2_rf_wr", rf_wr, 0);
      @(negedge clk);
      check("wr_n3_rsp_valid", rsp_valid, 0);
      check("wr_n3_cmd_ready", cmd_ready, 1);

      // fill and read back
      do_write(0, 8'h11);
      do_write(1, 8'h22);
      do_write(2, 8'h33);
      do_write(3, 8'h44);
      do_read(3, 8'h44);
      do_read(0, 8'h11);

      // back-pressured read
      rsp_ready = 1'b0;
      expect_rsp(1'b0, 8'h22);
      send(2'b01, 1, '0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("stall_rsp_valid", rsp_valid, 1);
         check("stall_rsp_data", rsp_data, 8'h22);
         check("stall_cmd_ready", cmd_ready, 0);
         check("stall_busy", busy, 1);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("stall_release_state", state_dbg, 3'd0);
      check("stall_release_rsp_valid", rsp_valid, 0);
      check("stall_hold_rsp_data", rsp_data, 8'h22);
      wait_done();

      // reserved op
      expect_rsp(1'b1, 8'h00);
      send(2'b11, 1, 8'hFF);
      check("rsv_rsp_valid", rsp_valid, 1);
      check("rsv_rsp_err", rsp_err, 1);
      check("rsv_rsp_data", rsp_data, 0);
      check("rsv_rf_wr", rf_wr, 0);
      wait_done();
      do_read(0, 8'h11);
      do_read(1, 8'h22);
      do_read(2, 8'h33);
      do_read(3, 8'h44);

`ifdef REGCTRL_CLEAR_EN
      // full clear
      for (int i = 0; i < 4; i++) expect_wr(AW'(i), 8'h00);
      expect_rsp(1'b0, 8'h00);
      send(2'b10, 3, 8'h5A);
      check("clr_n1_rf_wr", rf_wr, 1);
      check("clr_n1_rf_addr", rf_addr, 0);
      check("clr_n1_rf_d", rf_d, 0);
      wait_done();
      for (int i = 0; i < 4; i++) do_read(AW'(i), 8'h00);

      // clear aborted by reset in its second cycle
      do_write(0, 8'h11);
      do_write(1, 8'h22);
      do_write(2, 8'h33);
      do_write(3, 8'h44);
      expect_wr(0, 8'h00);
      expect_wr(1, 8'h00);
      send(2'b10, 0, 8'h00);
      @(negedge clk);
      check("abort_rf_addr", rf_addr, 1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_rf_wr", rf_wr, 0);
      check("abort_state", state_dbg, 3'd0);
      check("abort_rsp_valid", rsp_valid, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_wr_q_empty", wr_q.size(), 0);
      do_read(0, 8'h00);
      do_read(1, 8'h00);
      do_read(2, 8'h33);
      do_read(3, 8'h44);
`else
      // clear disabled: treated as an error
      expect_rsp(1'b1, 8'h00);
      send(2'b10, 2, 8'h77);
      check("clr_dis_rsp_valid", rsp_valid, 1);
      check("clr_dis_rsp_err", rsp_err, 1);
      check("clr_dis_rf_wr", rf_wr, 0);
      wait_done();
      do_read(0, 8'h11);
      do_read(3, 8'h44);
`endif

      // reset discards a pending response
      rsp_ready = 1'b0;
      send(2'b01, 3, '0);
      @(negedge clk);
      check("pend_rsp_valid", rsp_valid, 1);
      check("pend_rsp_data", rsp_data, 8'h44);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("pend_rst_rsp_valid", rsp_valid, 0);
      check("pend_rst_state", state_dbg, 3'd0);
      check("pend_rst_rsp_data", rsp_data, 0);
      check("pend_rst_cmd_ready", cmd_ready, 1);
      rsp_ready = 1'b1;
      repeat (4) @(negedge clk);
      do_write(1, 8'h5C);
      do_read(1, 8'h5C);

      check("final_exp_q_empty", exp_q.size(), 0);
      check("final_wr_q_empty", wr_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
